inst_prefetch: RTL and testbench

Instruction prefetch unit sitting between the pre-IF/IF pipeline stage and the instruction sram-like port of the AXI bridge. It issues sequential word fetches from a local PC and tags each in-order response with its PC. Responses are buffered in a small queue that decode drains with a valid/ready handshake. On a redirect, it flushes the queue, discards in-flight responses and restarts fetch from the new PC.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 68 ++++++
 rtl/inst_prefetch.sv | 140 ++++++++++++++
 tb/tb_inst_prefetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; used as PC-tag FIFO and instruction queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push,
  input  fetch_entry_t                   push_data,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t          mem [DEPTH];
  logic [PtrW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem[rd_q];
  assign do_pop  = pop && !empty && !flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = (rd_q == PtrW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      if (do_push) wr_d = (wr_q == PtrW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push) mem[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: sequential word fetch, PC tagging, decode queue, redirect flush.
// Optional FETCH_BYPASS_EN drives a response straight to decode when the queue is empty.
module inst_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fs_valid,
  input  logic        fs_ready,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_ex
);

  localparam int unsigned TCntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QCntW = $clog2(QUEUE_DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [TCntW-1:0] discard_q, discard_d;
  logic             ex_stall_q, ex_stall_d;

  // Tag FIFO occupancy is the outstanding-request count.
  logic [TCntW-1:0] outst;
  logic             tag_full, tag_empty;
  fetch_entry_t     tag_in, tag_head;
  logic [QCntW-1:0] q_count;
  logic             q_full, q_empty, q_push, q_pop;
  fetch_entry_t     q_in, q_head;
  logic [31:0]      reserved;
  logic             misaligned, accept, resp_keep, ex_push;

  assign misaligned = |pc_q[1:0];
  assign reserved   = 32'(q_count) + 32'(outst) - 32'(discard_q);
  assign inst_req   = resetn && !redirect_valid && !ex_stall_q && !misaligned &&
                      !tag_full && (reserved < QUEUE_DEPTH);
  assign inst_size  = INST_SIZE_WORD;
  assign inst_addr  = pc_q;
  assign accept     = inst_req && inst_addr_ok;

  assign resp_keep  = inst_data_ok && (discard_q == '0) && !redirect_valid;
  assign ex_push    = misaligned && !ex_stall_q && !redirect_valid &&
                      (outst == discard_q) && !q_full;

  assign tag_in = '{pc: pc_q, inst: 32'h0, ex: 1'b0};
  assign q_in   = resp_keep ? '{pc: tag_head.pc, inst: inst_rdata, ex: 1'b0}
                            : '{pc: pc_q, inst: 32'h0, ex: 1'b1};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass   = q_empty && (discard_q == '0) && inst_data_ok && !redirect_valid;
  assign fs_valid = !q_empty || bypass;
  assign fs_pc    = bypass ? tag_head.pc : q_head.pc;
  assign fs_inst  = bypass ? inst_rdata : q_head.inst;
  assign fs_ex    = bypass ? 1'b0 : q_head.ex;
  assign q_push   = (resp_keep && !(bypass && fs_ready)) || ex_push;
`else
  assign fs_valid = !q_empty;
  assign fs_pc    = q_head.pc;
  assign fs_inst  = q_head.inst;
  assign fs_ex    = q_head.ex;
  assign q_push   = resp_keep || ex_push;
`endif

  // A same-cycle redirect cancels the pop; the flush takes care of the head.
  assign q_pop = fs_valid && fs_ready && !redirect_valid;

  logic unused_tag;
  assign unused_tag = ^{tag_head.inst, tag_head.ex, tag_empty};

  fetch_queue #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_data (tag_in),
    .pop       (inst_data_ok),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (outst),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .resetn    (resetn),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    pc_d       = pc_q;
    discard_d  = discard_q;
    ex_stall_d = ex_stall_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      ex_stall_d = 1'b0;
      // Everything still in flight, minus a response landing now, is stale.
      discard_d  = outst - TCntW'(inst_data_ok);
    end else begin
      if (accept)                                  pc_d       = pc_q + 32'd4;
      if (ex_push)                                 ex_stall_d = 1'b1;
      if (inst_data_ok && (discard_q != '0))       discard_d  = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      discard_q  <= '0;
      ex_stall_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      ex_stall_q <= ex_stall_d;
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch with a fixed two-cycle-latency in-order bridge model.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fs_valid;
  logic        fs_ready = 1'b0;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_ex;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] rdata_q[$];
  int          cyc = 0;

  inst_prefetch dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fs_valid       (fs_valid),
    .fs_ready       (fs_ready),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst),
    .fs_ex          (fs_ex)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bridge: responses return in order two cycles after acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && inst_req && inst_addr_ok) pend.push_back('{due: cyc + 2, addr: inst_addr});
      @(posedge clk);
      #1;
      cyc++;
      inst_data_ok = 1'b0;
      if (!resetn) begin
        pend.delete();
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        inst_data_ok = 1'b1;
        inst_rdata   = (rdata_q.size() > 0) ? rdata_q.pop_front() : ~pend[0].addr;
        void'(pend.pop_front());
      end
    end
  end

  task automatic do_reset();
    step();
    resetn         = 1'b0;
    inst_addr_ok   = 1'b0;
    redirect_valid = 1'b0;
    fs_ready       = 1'b0;
    rdata_q.delete();
    repeat (3) step();
  endtask

  task automatic release_reset(input logic ok, input logic rdy);
    step();
    resetn       = 1'b1;
    inst_addr_ok = ok;
    fs_ready     = rdy;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(inst_req), 32'd0);
    check_eq("rst_addr", inst_addr, 32'hbfc0_0000);
    check_eq("rst_size", 32'(inst_size), 32'd2);
    check_eq("rst_valid", 32'(fs_valid), 32'd0);
    check_eq("rst_pc", fs_pc, 32'd0);
    check_eq("rst_inst", fs_inst, 32'd0);
    check_eq("rst_ex", 32'(fs_ex), 32'd0);

    // In-order fill with decode stalled, then drain
    rdata_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    release_reset(1'b1, 1'b0);
    @(negedge clk);
    check_eq("first_req", 32'(inst_req), 32'd1);
    check_eq("first_addr", inst_addr, 32'hbfc0_0000);
    repeat (9) step();
    @(negedge clk);
    check_eq("full_noreq", 32'(inst_req), 32'd0);
    check_eq("full_valid", 32'(fs_valid), 32'd1);
    step();
    fs_ready = 1'b1;
    @(negedge clk);
    check_eq("d0_pc", fs_pc, 32'hbfc0_0000);
    check_eq("d0_inst", fs_inst, 32'h11);
    check_eq("d0_noreq", 32'(inst_req), 32'd0);
    step();
    @(negedge clk);
    check_eq("resume_req", 32'(inst_req), 32'd1);
    check_eq("resume_addr", inst_addr, 32'hbfc0_0010);
    check_eq("d1_pc", fs_pc, 32'hbfc0_0004);
    check_eq("d1_inst", fs_inst, 32'h22);
    step();
    @(negedge clk);
    check_eq("d2_pc", fs_pc, 32'hbfc0_0008);
    check_eq("d2_inst", fs_inst, 32'h33);
    step();
    @(negedge clk);
    check_eq("d3_pc", fs_pc, 32'hbfc0_000c);
    check_eq("d3_inst", fs_inst, 32'h44);

    // Redirect in the cycle of the first response, two outstanding
    do_reset();
    release_reset(1'b1, 1'b1);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    check_eq("rd_dataok", 32'(inst_data_ok), 32'd1);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("rd_req", 32'(inst_req), 32'd1);
    check_eq("rd_addr", inst_addr, 32'h8000_0100);
    check_eq("rd_empty0", 32'(fs_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("rd_empty1", 32'(fs_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("rd_empty2", 32'(fs_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("rd_valid", 32'(fs_valid), 32'd1);
    check_eq("rd_pc", fs_pc, 32'h8000_0100);
    check_eq("rd_inst", fs_inst, 32'h7fff_feff);

    // Misaligned redirect raises one ADEF entry and stalls fetch
    do_reset();
    release_reset(1'b0, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("mis_noreq0", 32'(inst_req), 32'd0);
    step();
    @(negedge clk);
    check_eq("mis_valid", 32'(fs_valid), 32'd1);
    check_eq("mis_pc", fs_pc, 32'h8000_0102);
    check_eq("mis_ex", 32'(fs_ex), 32'd1);
    check_eq("mis_inst", fs_inst, 32'd0);
    check_eq("mis_noreq1", 32'(inst_req), 32'd0);
    step();
    fs_ready = 1'b1;
    step();
    fs_ready = 1'b0;
    @(negedge clk);
    check_eq("mis_once", 32'(fs_valid), 32'd0);
    check_eq("mis_stall", 32'(inst_req), 32'd0);
    step();
    inst_addr_ok   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("unstall_req", 32'(inst_req), 32'd1);
    check_eq("unstall_addr", inst_addr, 32'h8000_0200);

    // PC wraps past the top of the address space
    do_reset();
    release_reset(1'b1, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("wrap_req", 32'(inst_req), 32'd1);
    check_eq("wrap_addr0", inst_addr, 32'hffff_fffc);
    step();
    @(negedge clk);
    check_eq("wrap_addr1", inst_addr, 32'h0000_0000);

    // Response-to-decode latency into an empty queue
    do_reset();
    rdata_q = '{32'hdead_beef};
    release_reset(1'b1, 1'b1);
    step();
    inst_addr_ok = 1'b0;
    step();
    @(negedge clk);
    check_eq("lat_dataok", 32'(inst_data_ok), 32'd1);
`ifdef FETCH_BYPASS_EN
    check_eq("byp_valid", 32'(fs_valid), 32'd1);
    check_eq("byp_inst", fs_inst, 32'hdead_beef);
    check_eq("byp_pc", fs_pc, 32'hbfc0_0000);
    step();
    @(negedge clk);
    check_eq("byp_occ0", 32'(fs_valid), 32'd0);
`else
    check_eq("lat_novalid", 32'(fs_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("lat_valid", 32'(fs_valid), 32'd1);
    check_eq("lat_inst", fs_inst, 32'hdead_beef);
    check_eq("lat_pc", fs_pc, 32'hbfc0_0000);
    step();
    @(negedge clk);
    check_eq("lat_drained", 32'(fs_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
